// File: rtl/card_shuffler.sv
// card_shuffler: builds a Concentration board (each face value twice) and
// applies a Fisher-Yates shuffle driven by words requested from the RNG.
// Optional build macro SHUFFLE_CHECK_EN adds a pair-count CHECK pass and err flag.
module card_shuffler #(
  parameter int unsigned NUM_CARDS = 16,
  parameter int unsigned IDX_W     = 4,
  parameter int unsigned VAL_W     = 3
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [31:0]      randNum,
  output logic             changeNum,
  output logic             busy,
  output logic             done,
  input  logic [IDX_W-1:0] rd_addr,
  output logic [VAL_W-1:0] rd_val,
  output logic             err
);

  localparam int unsigned PW = 17 + IDX_W;
  localparam logic [IDX_W-1:0] LAST = IDX_W'(NUM_CARDS - 1);

  typedef enum logic [2:0] {
    IDLE, INIT, REQ, WAIT1, WAIT2, SWAP, CHECK, DONE
  } state_t;

  state_t           state, next_state;
  logic             busy_nxt, done_nxt, change_nxt;
  logic [IDX_W-1:0] cnt;
  logic [VAL_W-1:0] deck [NUM_CARDS];
  logic [IDX_W:0]   ip1_c;
  logic [PW-1:0]    prod_c;
  logic [IDX_W-1:0] j_c;
  logic             unused_bits;

  // Swap partner: j = (rand16 * (i+1)) >> 16, always within 0..i
  assign ip1_c       = {1'b0, cnt} + (IDX_W+1)'(1);
  assign prod_c      = PW'(randNum[15:0]) * PW'(ip1_c);
  assign j_c         = prod_c[16 +: IDX_W];
  assign unused_bits = ^{randNum[31:16], prod_c[15:0], prod_c[PW-1]};

  // Random-access read port, live even mid-shuffle
  assign rd_val = deck[rd_addr];

  // Next-state and registered-output decode
  always_comb begin
    next_state = state;
    busy_nxt   = 1'b0;
    done_nxt   = 1'b0;
    change_nxt = 1'b0;
    case (state)
      IDLE:  if (start) next_state = INIT;
      INIT:  if (cnt == LAST) next_state = REQ;
      REQ:   next_state = WAIT1;
      WAIT1: next_state = WAIT2;
      WAIT2: next_state = SWAP;
      SWAP: begin
        if (cnt == IDX_W'(1)) begin
`ifdef SHUFFLE_CHECK_EN
          next_state = CHECK;
`else
          next_state = DONE;
`endif
        end else begin
          next_state = REQ;
        end
      end
      CHECK: if (cnt == LAST) next_state = DONE;
      DONE:  next_state = IDLE;
      default: next_state = IDLE;
    endcase
    busy_nxt   = (next_state inside {INIT, REQ, WAIT1, WAIT2, SWAP, CHECK});
    done_nxt   = (next_state == DONE);
    change_nxt = (next_state == REQ);
  end

  // State register and registered status outputs
  always_ff @(posedge clk) begin
    if (!reset) begin
      state     <= IDLE;
      changeNum <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      state     <= next_state;
      changeNum <= change_nxt;
      busy      <= busy_nxt;
      done      <= done_nxt;
    end
  end

  // Deck fill / swap datapath; cnt is k in INIT, i in the swap loop, card in CHECK
  always_ff @(posedge clk) begin
    if (!reset) begin
      cnt <= '0;
      for (int k = 0; k < int'(NUM_CARDS); k++) deck[k] <= '0;
    end else begin
      case (state)
        IDLE: cnt <= '0;
        INIT: begin
          deck[cnt] <= VAL_W'(cnt >> 1);
          if (cnt != LAST) cnt <= cnt + IDX_W'(1);
        end
        SWAP: begin
          deck[cnt] <= deck[j_c];
          deck[j_c] <= deck[cnt];
          cnt       <= (cnt == IDX_W'(1)) ? '0 : cnt - IDX_W'(1);
        end
        CHECK: cnt <= cnt + IDX_W'(1);
        default: ;
      endcase
    end
  end

`ifdef SHUFFLE_CHECK_EN
  logic [IDX_W:0] tally [NUM_CARDS/2];
  logic [IDX_W:0] sum_c;
  logic           bad_c;

  // Final tally including the card being counted this cycle
  always_comb begin
    bad_c = 1'b0;
    sum_c = '0;
    for (int v = 0; v < int'(NUM_CARDS/2); v++) begin
      sum_c = tally[v] + ((deck[cnt] == VAL_W'(v)) ? (IDX_W+1)'(1) : (IDX_W+1)'(0));
      if (sum_c != (IDX_W+1)'(2)) bad_c = 1'b1;
    end
  end

  // Per-value occurrence counters and sticky err flag
  always_ff @(posedge clk) begin
    if (!reset) begin
      err <= 1'b0;
      for (int v = 0; v < int'(NUM_CARDS/2); v++) tally[v] <= '0;
    end else if (state == IDLE && start) begin
      err <= 1'b0;
      for (int v = 0; v < int'(NUM_CARDS/2); v++) tally[v] <= '0;
    end else if (state == CHECK) begin
      tally[deck[cnt]] <= tally[deck[cnt]] + (IDX_W+1)'(1);
      if (cnt == LAST) err <= bad_c;
    end
  end
`else
  assign err = 1'b0;
`endif

endmodule

// File: tb/tb_card_shuffler.sv
// Self-checking bench for card_shuffler: cycle-exact changeNum/done scoreboard,
// software Fisher-Yates reference deck, reset abort and read-port checks.
module tb_card_shuffler;
  localparam int N  = 16;
  localparam int IW = 4;
  localparam int VW = 3;
`ifdef SHUFFLE_CHECK_EN
  localparam int LAT = 93;
`else
  localparam int LAT = 77;
`endif

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          start = 1'b0;
  logic [31:0]   randNum = '0;
  logic          changeNum, busy, done, err;
  logic [IW-1:0] rd_addr = '0;
  logic [VW-1:0] rd_val;

  int          checks = 0;
  int          errors = 0;
  int          mdeck [N];
  int          mi;
  int unsigned rng = 32'h1234_5678;
  int          exp_done_q [$];
  int          exp_cn_q [$];

  card_shuffler #(.NUM_CARDS(N), .IDX_W(IW), .VAL_W(VW)) dut (
    .clk(clk), .reset(reset), .start(start), .randNum(randNum),
    .changeNum(changeNum), .busy(busy), .done(done),
    .rd_addr(rd_addr), .rd_val(rd_val), .err(err)
  );

  always #20 clk = ~clk;

  task automatic next_word(input int mode, output logic [31:0] w);
    if (mode == 0) w = 32'h0;
    else if (mode == 1) w = 32'hFFFF_FFFF;
    else begin
      rng = rng ^ (rng << 13);
      rng = rng ^ (rng >> 17);
      rng = rng ^ (rng << 5);
      w = rng;
    end
  endtask

  task automatic model_swap(input logic [31:0] w);
    int unsigned p;
    int j, t;
    p = 32'(w[15:0]) * 32'(mi + 1);
    j = int'(p >> 16);
    t = mdeck[mi]; mdeck[mi] = mdeck[j]; mdeck[j] = t;
    mi--;
  endtask

  // One full shuffle with scoreboarded timing; optional stray start / mid-run reset
  task automatic run_shuffle(input int mode, input int extra_start, input int reset_at);
    logic [31:0] w;
    int e;
    int tally [N/2];
    for (int k = 0; k < N; k++) mdeck[k] = k >> 1;
    mi = N - 1;
    exp_done_q.push_back(LAT);
    for (int t = 0; t < N - 1; t++) exp_cn_q.push_back(N + 1 + 4 * t);
    @(negedge clk);
    start = 1'b1;
    for (int n = 1; n <= LAT + 8; n++) begin
      @(negedge clk);
      start = (n == extra_start);
      if (n == reset_at) begin
        reset = 1'b0;
        @(negedge clk);
        checks++;
        if ({busy, done, changeNum} !== 3'b000) begin
          errors++;
          $display("FAIL reset_abort_outs busy/done/changeNum got %b expected 000", {busy, done, changeNum});
        end
        for (int k = 0; k < N; k++) begin
          rd_addr = IW'(k); #1;
          checks++;
          if (rd_val !== '0) begin
            errors++;
            $display("FAIL reset_abort_deck deck[%0d] got %0d expected 0", k, rd_val);
          end
        end
        reset = 1'b1;
        exp_done_q.delete();
        exp_cn_q.delete();
        for (int c = 0; c < 100; c++) begin
          @(negedge clk);
          checks++;
          if (done !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL reset_abort_idle cycle %0d done=%b busy=%b expected 0 0", c, done, busy);
          end
        end
        return;
      end
      checks++;
      if (busy !== (n < LAT)) begin
        errors++;
        $display("FAIL busy cycle %0d got %b expected %b", n, busy, (n < LAT));
      end
      if (changeNum === 1'b1) begin
        checks++;
        if (exp_cn_q.size() == 0) begin
          errors++;
          $display("FAIL changenum_extra cycle %0d got pulse expected none", n);
        end else begin
          e = exp_cn_q.pop_front();
          if (e != n) begin
            errors++;
            $display("FAIL changenum_cycle got %0d expected %0d", n, e);
          end
        end
        next_word(mode, w);
        randNum = w;
        if (mi >= 1) model_swap(w);
      end
      if (done === 1'b1) begin
        checks++;
        if (exp_done_q.size() == 0) begin
          errors++;
          $display("FAIL done_extra cycle %0d got pulse expected none", n);
        end else begin
          e = exp_done_q.pop_front();
          if (e != n) begin
            errors++;
            $display("FAIL done_cycle got %0d expected %0d", n, e);
          end
        end
        checks++;
        if (err !== 1'b0) begin
          errors++;
          $display("FAIL err_at_done got %b expected 0", err);
        end
      end
    end
    checks++;
    if (exp_done_q.size() != 0 || exp_cn_q.size() != 0) begin
      errors++;
      $display("FAIL missing_pulses done_left=%0d changenum_left=%0d expected 0 0", exp_done_q.size(), exp_cn_q.size());
      exp_done_q.delete();
      exp_cn_q.delete();
    end
    for (int v = 0; v < N / 2; v++) tally[v] = 0;
    for (int k = 0; k < N; k++) begin
      rd_addr = IW'(k); #1;
      checks++;
      if (rd_val !== VW'(mdeck[k])) begin
        errors++;
        $display("FAIL deck_model deck[%0d] got %0d expected %0d", k, rd_val, mdeck[k]);
      end
      if (!$isunknown(rd_val)) tally[rd_val]++;
    end
    for (int v = 0; v < N / 2; v++) begin
      checks++;
      if (tally[v] != 2) begin
        errors++;
        $display("FAIL pair_count value %0d got %0d expected 2", v, tally[v]);
      end
    end
  endtask

  task automatic test_reset;
    reset = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if ({busy, done, changeNum, err} !== 4'b0000) begin
      errors++;
      $display("FAIL reset_outs busy/done/changeNum/err got %b expected 0000", {busy, done, changeNum, err});
    end
    for (int k = 0; k < N; k++) begin
      rd_addr = IW'(k); #1;
      checks++;
      if (rd_val !== '0) begin
        errors++;
        $display("FAIL reset_deck deck[%0d] got %0d expected 0", k, rd_val);
      end
    end
    reset = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_zero_rng;
    int exp0 [N] = '{0, 1, 1, 2, 2, 3, 3, 4, 4, 5, 5, 6, 6, 7, 7, 0};
    run_shuffle(0, 0, 0);
    for (int k = 0; k < N; k++) begin
      rd_addr = IW'(k); #1;
      checks++;
      if (rd_val !== VW'(exp0[k])) begin
        errors++;
        $display("FAIL zero_rng_deck deck[%0d] got %0d expected %0d", k, rd_val, exp0[k]);
      end
    end
  endtask

  task automatic test_max_rng;
    run_shuffle(1, 0, 0);
    for (int k = 0; k < N; k++) begin
      rd_addr = IW'(k); #1;
      checks++;
      if (rd_val !== VW'(k >> 1)) begin
        errors++;
        $display("FAIL max_rng_deck deck[%0d] got %0d expected %0d", k, rd_val, k >> 1);
      end
    end
  endtask

  task automatic test_start_while_busy;
    rng = 32'hCAFE_F00D;
    run_shuffle(2, 30, 0);
  endtask

  task automatic test_reset_mid;
    rng = 32'h0BAD_5EED;
    run_shuffle(2, 0, 40);
    run_shuffle(2, 0, 0);
  endtask

  task automatic test_random_boards;
    for (int s = 0; s < 50; s++) begin
      rng = $urandom | 32'h1;
      run_shuffle(2, 0, 0);
    end
  endtask

  task automatic test_readport;
    for (int c = 0; c < 100; c++) begin
      @(negedge clk);
      rd_addr = IW'(c % N); #1;
      checks++;
      if (rd_val !== VW'(mdeck[c % N])) begin
        errors++;
        $display("FAIL readport cycle %0d deck[%0d] got %0d expected %0d", c, c % N, rd_val, mdeck[c % N]);
      end
    end
  endtask

  initial begin
    test_reset();
    test_zero_rng();
    test_max_rng();
    test_start_while_busy();
    test_reset_mid();
    test_random_boards();
    test_readport();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/card_shuffler.md
Name: card_shuffler

Overview:
- Consumes `randNum` from the RNG block and produces a shuffled Concentration board.
- The board is NUM_CARDS cards, with each face value occurring exactly twice.
- The shuffle is Fisher-Yates, driven by the RNG's `changeNum` request line.
- Sits between the RNG and the game controller / display, which read card faces through a random-access read port.

Parameters:
- NUM_CARDS, 16, number of cards; must be even and at most 64.
- IDX_W, 4, card index width; equals clog2(NUM_CARDS).
- VAL_W, 3, face value width; equals clog2(NUM_CARDS/2).

Ports:
- clk  input  1  system clock.
- reset  input  1  synchronous, active-low reset.
- start  input  1  one-cycle request to build and shuffle a new board; sampled only in IDLE.
- randNum  input  32  random word from the RNG.
- changeNum  output  1  request to the RNG for a new number; registered.
- busy  output  1  high from the first INIT cycle through the last work cycle.
- done  output  1  one-cycle pulse when the board is ready.
- rd_addr  input  IDX_W  card index to read.
- rd_val  output  VAL_W  combinational read, equal to deck[rd_addr].
- err  output  1  pair-check failure flag; see Optional Feature.

Behaviour:
- Storage: deck[0..NUM_CARDS-1], VAL_W bits each, held in a register array.
- Reset (reset==0 at a clk edge):
  - state returns to IDLE and all deck entries clear to 0.
  - changeNum, busy, done and err all go to 0.
  - Reset applies in any state; an in-progress shuffle is abandoned with no done pulse.
- States:
  - IDLE → INIT on start==1. start in any other state is ignored.
  - INIT: one cycle per index k = 0..NUM_CARDS-1, writing deck[k] = k>>1. After k = NUM_CARDS-1, set i = NUM_CARDS-1 and go to REQ.
  - REQ: changeNum=1 for exactly this one cycle. Then WAIT1, then WAIT2; the RNG must present its new word within 2 cycles.
  - SWAP: sample randNum and compute j = (randNum[15:0] * (i+1)) >> 16. The multiply is unsigned, 16 bits × (IDX_W+1) bits; j always lies in 0..i. Exchange deck[i] and deck[j] in the same cycle; j==i leaves the deck unchanged. If i==1, go to DONE (or CHECK when the feature is enabled); otherwise decrement i and go to REQ.
  - DONE: done=1 and busy=0 for one cycle, then IDLE.
- busy is 1 in INIT, REQ, WAIT1, WAIT2, SWAP and CHECK; 0 otherwise.
- Latency for NUM_CARDS=16: with start sampled at edge 0, INIT covers cycles 1-16 and the 15 iterations of 4 cycles cover cycles 17-76. done is high in cycle 77.
- In general, done falls NUM_CARDS + 4*(NUM_CARDS-1) + 1 cycles after start.
- rd_val always reflects the current array, including mid-shuffle. Consumers read only after done.
- The deck holds its contents in IDLE until the next start or reset.

Optional Feature:
- Macro: SHUFFLE_CHECK_EN.
- Defined:
  - After the final SWAP, a CHECK state runs for NUM_CARDS cycles, one card per cycle, counting occurrences of each value.
  - err is set in the DONE cycle if any value count ≠ 2, and holds until the next start or reset.
  - err clears on the cycle start is accepted.
  - Latency grows by NUM_CARDS cycles, so done lands in cycle 93 for 16 cards.
- Not defined: no CHECK state, err tied to 0, latency as above.

Test Plan:
1. Reset, then hold randNum=0 and pulse start → every j=0. After done, deck[0..15] = 0,1,1,2,2,3,3,4,4,5,5,6,6,7,7,0. done in cycle 77, with 15 changeNum pulses, each exactly 1 cycle wide, spaced 4 cycles apart.
2. Hold randNum=32'hFFFFFFFF and start → j=i on every step. Final deck is unchanged from INIT: 0,0,1,1,…,7,7.
3. Pulse start again while busy, e.g. in cycle 30 → ignored. Exactly one done, still in cycle 77.
4. Drive reset=0 during cycle 40 → next cycle busy=0, done=0, changeNum=0 and all deck reads return 0. No done pulse follows. A new start runs the full 77-cycle sequence.
5. Feed a free-running RNG with arbitrary seeds across 50 shuffles → after each done, every value 0..7 appears exactly twice. With SHUFFLE_CHECK_EN, err stays 0 and done arrives in cycle 93.
6. After done, sweep rd_addr over 0..15 → rd_val is valid combinationally in the same cycle and stable over 100 idle cycles.
